// File: rtl/modport_fifo.sv
// modport_fifo: single-clock FIFO of DEPTH x DATA_WIDTH words between a producer and a consumer.
// Latency: a word written at edge N is readable at edge N+1. The registered read updates o_rddata
//          on the edge that accepts the read. Under MODPORT_FIFO_FWFT_EN the head word is shown
//          combinationally instead.
// Backpressure: none beyond the enables. A write while full and a read while empty are dropped silently.
//
// Build option: define MODPORT_FIFO_FWFT_EN for first-word fall-through read data.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   i_wrdata     write data
//   i_wren       write request
//   i_rden       read request
//   o_full       count == DEPTH
//   o_empty      count == 0
//   o_alm_full   count >= ALM_FULL_LVL
//   o_alm_empty  count <= ALM_EMPTY_LVL
//   o_rddata     read data
module modport_fifo #(
  parameter int DATA_WIDTH    = 128,
  parameter int DEPTH         = 16,
  parameter int ALM_FULL_LVL  = DEPTH - 2,
  parameter int ALM_EMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_wrdata,
  input  logic                  i_wren,
  input  logic                  i_rden,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_alm_full,
  output logic                  o_alm_empty,
  output logic [DATA_WIDTH-1:0] o_rddata
);

  localparam int AW = $clog2(DEPTH);

  // Thresholds sized to the count register so the flag compares are width-matched.
  localparam logic [AW:0] LP_FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ALM_FULL  = (AW+1)'(ALM_FULL_LVL);
  localparam logic [AW:0] LP_ALM_EMPTY = (AW+1)'(ALM_EMPTY_LVL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags come only from the registered count, never from same-cycle requests.
  assign w_full      = (r_count == LP_FULL);
  assign w_empty     = (r_count == '0);
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_alm_full  = (r_count >= LP_ALM_FULL);
  assign o_alm_empty = (r_count <= LP_ALM_EMPTY);

  // Gating on the current flags means a full FIFO with both requests takes only
  // the read, and an empty FIFO with both requests takes only the write.
  assign w_wr_acc = i_wren && !w_full;
  assign w_rd_acc = i_rden && !w_empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= i_wrdata;
    end
  end

`ifdef MODPORT_FIFO_FWFT_EN
  assign o_rddata = r_mem[r_rptr];
`else
  logic [DATA_WIDTH-1:0] r_rddata;
  assign o_rddata = r_rddata;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
`ifndef MODPORT_FIFO_FWFT_EN
      r_rddata <= '0;
`endif
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
`ifndef MODPORT_FIFO_FWFT_EN
        r_rddata <= r_mem[r_rptr];
`endif
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: bench for modport_fifo in its default registered-read build.
// The driver issues directed vectors and queues the words the FIFO should return.
// A separate monitor pops the queue and compares on every accepted read.
module tb_modport_fifo;

  localparam int DW = 128;

  logic          clk;
  logic          rst;
  logic [DW-1:0] i_wrdata;
  logic          i_wren;
  logic          i_rden;
  logic          o_full;
  logic          o_empty;
  logic          o_alm_full;
  logic          o_alm_empty;
  logic [DW-1:0] o_rddata;

  int n_tests;
  int n_fail;
  int mcount;                 // bench occupancy model, used only to decide what is accepted
  logic [DW-1:0] exp_q [$];   // scoreboard of words expected out of the FIFO

  modport_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(16),
    .ALM_FULL_LVL(14),
    .ALM_EMPTY_LVL(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wrdata   (i_wrdata),
    .i_wren     (i_wren),
    .i_rden     (i_rden),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_alm_full (o_alm_full),
    .o_alm_empty(o_alm_empty),
    .o_rddata   (o_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic e_empty, input logic e_ae,
                           input logic e_af, input logic e_full);
    check({name, ".flags"}, {124'd0, o_empty, o_alm_empty, o_alm_full, o_full},
          {124'd0, e_empty, e_ae, e_af, e_full});
  endtask

  // Drive one cycle starting from a falling edge and return on the next falling edge.
  task automatic cyc(input logic wr, input logic rd, input logic [DW-1:0] d);
    logic wacc;
    logic racc;
    wacc = wr && (mcount != 16);
    racc = rd && (mcount != 0);
    if (wacc) exp_q.push_back(d);
    mcount = mcount + (wacc ? 1 : 0) - (racc ? 1 : 0);
    i_wren   = wr;
    i_rden   = rd;
    i_wrdata = d;
    @(negedge clk);
    i_wren = 1'b0;
    i_rden = 1'b0;
  endtask

  // Monitor: inputs are stable at the rising edge and o_empty still holds its pre-edge value here.
  logic          mon_acc;
  logic [DW-1:0] mon_exp;
  always @(posedge clk) begin
    mon_acc = rst && i_rden && !o_empty;
    if (mon_acc) begin
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got %h expected no read", o_rddata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", o_rddata, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    mcount   = 0;
    rst      = 1'b0;
    i_wren   = 1'b0;
    i_rden   = 1'b0;
    i_wrdata = '0;

    repeat (2) @(negedge clk);
    chk_flags("reset_hold", 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_hold.rddata", o_rddata, '0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    chk_flags("reset_release", 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_release.rddata", o_rddata, '0);

    // Fill with 1..16.
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'b0, DW'(k));
      chk_flags($sformatf("fill%0d", k), 1'b0, (k <= 2), (k >= 14), (k == 16));
    end

    // Write while full is dropped.
    cyc(1'b1, 1'b0, DW'(128'hDEAD));
    chk_flags("write_when_full", 1'b0, 1'b0, 1'b1, 1'b1);

    // Drain; the monitor checks each word one cycle after i_rden.
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b1, '0);
      chk_flags($sformatf("drain%0d", k), (k == 16), ((16 - k) <= 2), ((16 - k) >= 14), 1'b0);
    end
    check("drain_last", o_rddata, DW'(128'h10));

    // Read while empty holds data and flags.
    cyc(1'b0, 1'b1, '0);
    check("read_when_empty.rddata", o_rddata, DW'(128'h10));
    chk_flags("read_when_empty", 1'b1, 1'b1, 1'b0, 1'b0);

    // Both requests while empty: only the write is taken.
    cyc(1'b1, 1'b1, DW'(128'h100));
    check("both_when_empty.rddata", o_rddata, DW'(128'h10));
    chk_flags("both_when_empty", 1'b0, 1'b1, 1'b0, 1'b0);

    // Bring count to 5, then stream through pointer wrap with the count held at 5.
    for (int k = 1; k < 5; k++) cyc(1'b1, 1'b0, DW'(128'h100 + k));
    chk_flags("count5", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b1, DW'(128'h105 + k));
      chk_flags($sformatf("stream%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("stream_last", o_rddata, DW'(128'h113));

    // Store 8 more entries and reset mid-stream.
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, DW'(128'h200 + k));
    chk_flags("count13", 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_flags("mid_reset", 1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_reset.rddata", o_rddata, '0);
    exp_q.delete();
    mcount = 0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 1'b0, DW'(128'hBEEF));
    chk_flags("post_reset_wr", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, '0);
    check("post_reset_rd", o_rddata, DW'(128'hBEEF));
    chk_flags("post_reset_rd", 1'b1, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", DW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
